s3_ctrl_pipe: RTL and testbench

S3_CTRL_PIPE -- requirements
Module: s3_ctrl_pipe

---
 rtl/s3_ctrl_pkg.sv | 39 +++
 rtl/s3_decode.sv | 55 +++++
 rtl/s3_ctrl_pipe.sv | 140 ++++++++++++++
 tb/tb_s3_ctrl_pipe.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/s3_ctrl_pkg.sv
// Shared control definitions for the stage-3 controller: opcode fields,
// next-PC and writeback encodings, and the controller state enumeration.
package s3_ctrl_pkg;

    // Opcode constants are inst[6:2]; the low two bits are always 2'b11.
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_OP_IMM = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam logic [2:0]  MEM_SEL_WORD = 3'b010;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        PC_ALU   = 2'd1,
        PC_JAL   = 2'd2,
        PC_RESET = 2'd3
    } pc_sel_e;

    typedef enum logic [1:0] {
        WB_MEM = 2'd0,
        WB_ALU = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_LOAD_WAIT
    } state_e;

endpackage

// File: rtl/s3_decode.sv
// Combinational decode of the stage-3 instruction into writeback, memory
// format and control-flow class. Unknown opcodes decode as a NOP.
module s3_decode
    import s3_ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic [2:0] funct3,
    output wb_sel_e    wb_sel,
    output logic [2:0] mem_sel,
    output logic       reg_write,
    output logic       csr_write,
    output logic       is_jal,
    output logic       is_jalr,
    output logic       is_branch
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
        wb_sel    = WB_ALU;
        mem_sel   = MEM_SEL_WORD;
        reg_write = 1'b0;
        csr_write = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        is_branch = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_OP, OP_OP_IMM: reg_write = 1'b1;
            OP_JAL: begin
                wb_sel    = WB_PC4;
                reg_write = 1'b1;
                is_jal    = 1'b1;
            end
            OP_JALR: begin
                wb_sel    = WB_PC4;
                reg_write = 1'b1;
                is_jalr   = 1'b1;
            end
            OP_LOAD: begin
                wb_sel    = WB_MEM;
                mem_sel   = funct3;
                reg_write = 1'b1;
            end
            OP_BRANCH: is_branch = 1'b1;
            OP_SYSTEM: begin
                // funct3==0 is ecall/ebreak/mret territory and stays a NOP here.
                if (funct3 != 3'b000) begin
                    reg_write = 1'b1;
                    csr_write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/s3_ctrl_pipe.sv
// Stage-3 pipeline register plus its controller: boot hold, multi-cycle load
// wait, redirect/flush generation and register-file/CSR write qualification.
module s3_ctrl_pipe
    import s3_ctrl_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int LOAD_LAT   = 1,
    parameter int RESET_HOLD = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            valid_in,
    input  logic            br_taken_in,
    input  logic            br_pred_in,
    input  logic            stall_in,
    output logic [31:0]     inst_s3,
    output logic [XLEN-1:0] pc_s3,
    output logic            valid_s3,
    output logic [2:0]      mem_sel,
    output logic [1:0]      wb_sel,
    output logic [1:0]      pc_sel,
    output logic            reg_we,
    output logic            csr_we,
    output logic            stall_out,
    output logic            flush_out
);

    localparam logic [3:0] BOOT_LAST = 4'(RESET_HOLD - 1);
    localparam logic [1:0] WAIT_INIT = 2'(LOAD_LAT - 1);
    localparam bit         HAS_WAIT  = (LOAD_LAT > 1);

    state_e     state, state_next;
    logic [3:0] boot_cnt, boot_cnt_next;
    logic [1:0] wait_cnt, wait_cnt_next;
    logic       taken_s3, pred_s3;
    logic       capture;
    pc_sel_e    pc_sel_n;
    wb_sel_e    wb_sel_d;
    logic       reg_write, csr_write, is_jal, is_jalr, is_branch;

    s3_decode u_decode (
        .opcode    (inst_s3[6:2]),
        .funct3    (inst_s3[14:12]),
        .wb_sel    (wb_sel_d),
        .mem_sel   (mem_sel),
        .reg_write (reg_write),
        .csr_write (csr_write),
        .is_jal    (is_jal),
        .is_jalr   (is_jalr),
        .is_branch (is_branch)
    );

    // Only RUN captures: BOOT never loads and LOAD_WAIT is the internal stall.
    assign capture = (state == ST_RUN) && !stall_in;
    assign pc_sel  = pc_sel_n;
    assign wb_sel  = wb_sel_d;

    always_ff @(posedge clk) begin
        // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state    <= ST_BOOT;
            boot_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            boot_cnt <= boot_cnt_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_s3  <= NOP_INST;
            pc_s3    <= '0;
            valid_s3 <= 1'b0;
            taken_s3 <= 1'b0;
            pred_s3  <= 1'b0;
        end else if (capture) begin
            inst_s3  <= inst_in;
            pc_s3    <= pc_in;
            // A live redirect means stage 2 holds a wrong-path instruction.
            valid_s3 <= valid_in && !flush_out;
            taken_s3 <= br_taken_in;
            pred_s3  <= br_pred_in;
        end
    end

    always_comb begin
        state_next    = state;
        boot_cnt_next = boot_cnt;
        wait_cnt_next = wait_cnt;
        pc_sel_n      = PC_PLUS4;
        flush_out     = 1'b0;
        reg_we        = 1'b0;
        csr_we        = 1'b0;
        stall_out     = 1'b0;
        case (state)
            ST_BOOT: begin
                pc_sel_n = PC_RESET;
                if (boot_cnt == BOOT_LAST) begin
                    state_next    = ST_RUN;
                    boot_cnt_next = '0;
                end else begin
                    boot_cnt_next = boot_cnt + 4'd1;
                end
            end
            ST_RUN: begin
                if (valid_s3) begin
                    if (is_jal)
                        pc_sel_n = PC_JAL;
                    else if (is_jalr || (is_branch && (taken_s3 != pred_s3)))
                        pc_sel_n = PC_ALU;
                    reg_we = reg_write && (inst_s3[11:7] != 5'd0);
                    csr_we = csr_write;
                end
                flush_out = (pc_sel_n == PC_ALU) || (pc_sel_n == PC_JAL);
                if (HAS_WAIT && capture && valid_in && !flush_out &&
                    (inst_in[6:2] == OP_LOAD)) begin
                    state_next    = ST_LOAD_WAIT;
                    wait_cnt_next = WAIT_INIT;
                end
            end
            ST_LOAD_WAIT: begin
                stall_out = 1'b1;
                if (!stall_in) begin
                    if (wait_cnt <= 2'd1) begin
                        state_next    = ST_RUN;
                        wait_cnt_next = '0;
                    end else begin
                        wait_cnt_next = wait_cnt - 2'd1;
                    end
                end
            end
            default: state_next = ST_BOOT;
        endcase
    end

endmodule

// File: tb/tb_s3_ctrl_pipe.sv
// Directed bench for s3_ctrl_pipe (LOAD_LAT=3, RESET_HOLD=2): each driven cycle
// pushes its expected stage-3 view to a scoreboard, popped just after the edge.
module tb_s3_ctrl_pipe;

    localparam int DC = -1;

    localparam logic [31:0] I_NOP   = 32'h0000_0013;
    localparam logic [31:0] I_ADDI  = 32'h0050_0193;
    localparam logic [31:0] I_LW    = 32'h0002_A283;
    localparam logic [31:0] I_LBU   = 32'h0002_C283;
    localparam logic [31:0] I_BEQ   = 32'h0000_0063;
    localparam logic [31:0] I_JAL0  = 32'h0000_006F;
    localparam logic [31:0] I_JAL1  = 32'h0000_00EF;
    localparam logic [31:0] I_JALR  = 32'h0001_00E7;
    localparam logic [31:0] I_CSRRW = 32'h3000_9073;
    localparam logic [31:0] I_CUST  = 32'h0000_000B;
    localparam logic [31:0] I_ECALL = 32'h0000_0073;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_in, pc_in;
    logic        valid_in, br_taken_in, br_pred_in, stall_in;
    logic [31:0] inst_s3, pc_s3;
    logic        valid_s3;
    logic [2:0]  mem_sel;
    logic [1:0]  wb_sel, pc_sel;
    logic        reg_we, csr_we, stall_out, flush_out;

    always #5 clk = ~clk;

    s3_ctrl_pipe #(.XLEN(32), .LOAD_LAT(3), .RESET_HOLD(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_in     (inst_in),
        .pc_in       (pc_in),
        .valid_in    (valid_in),
        .br_taken_in (br_taken_in),
        .br_pred_in  (br_pred_in),
        .stall_in    (stall_in),
        .inst_s3     (inst_s3),
        .pc_s3       (pc_s3),
        .valid_s3    (valid_s3),
        .mem_sel     (mem_sel),
        .wb_sel      (wb_sel),
        .pc_sel      (pc_sel),
        .reg_we      (reg_we),
        .csr_we      (csr_we),
        .stall_out   (stall_out),
        .flush_out   (flush_out)
    );

    typedef struct {
        string tag;
        int    v, ps, st, fl, we, csr, wb, mem, pc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input int v, input int ps, input int st,
                                input int fl, input int we, input int csr, input int wb,
                                input int mem, input int pc);
        exp_t e;
        e.tag = tag; e.v = v; e.ps = ps; e.st = st; e.fl = fl;
        e.we = we; e.csr = csr; e.wb = wb; e.mem = mem; e.pc = pc;
        return e;
    endfunction

    task automatic score();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: got=0 entries exp=1");
            return;
        end
        e = sb.pop_front();
        check({e.tag, ".valid"}, 32'(valid_s3), e.v);
        check({e.tag, ".pc_sel"}, 32'(pc_sel), e.ps);
        check({e.tag, ".stall"}, 32'(stall_out), e.st);
        check({e.tag, ".flush"}, 32'(flush_out), e.fl);
        check({e.tag, ".reg_we"}, 32'(reg_we), e.we);
        check({e.tag, ".csr_we"}, 32'(csr_we), e.csr);
        check({e.tag, ".pc_s3"}, pc_s3, e.pc);
        if (e.wb != DC) check({e.tag, ".wb_sel"}, 32'(wb_sel), e.wb);
        if (e.mem != DC) check({e.tag, ".mem_sel"}, 32'(mem_sel), e.mem);
    endtask

    task automatic step(input logic [31:0] inst, input logic [31:0] pc, input logic v,
                        input logic tk, input logic pd, input logic stl, input logic r,
                        input exp_t e);
        inst_in     = inst;
        pc_in       = pc;
        valid_in    = v;
        br_taken_in = tk;
        br_pred_in  = pd;
        stall_in    = stl;
        rst         = r;
        sb.push_back(e);
        @(posedge clk);
        #1;
        score();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; inst_in = I_NOP; pc_in = '0; valid_in = 1'b0;
        br_taken_in = 1'b0; br_pred_in = 1'b0; stall_in = 1'b0;

        // Reset pulse and boot hold
        step(I_NOP,  32'h000, 0, 0, 0, 0, 1, mk("rst",       0, 3, 0, 0, 0, 0, DC, DC, 0));
        check("rst.inst_s3", inst_s3, I_NOP);
        step(I_ADDI, 32'h100, 1, 0, 0, 0, 0, mk("boot1",     0, 3, 0, 0, 0, 0, DC, DC, 0));
        step(I_ADDI, 32'h100, 1, 0, 0, 0, 0, mk("boot_exit", 0, 0, 0, 0, 0, 0, DC, DC, 0));
        step(I_ADDI, 32'h100, 1, 0, 0, 0, 0, mk("addi",      1, 0, 0, 0, 1, 0, 1, 2, 'h100));

        // Three-cycle load: two stall cycles then the write
        step(I_LW,   32'h104, 1, 0, 0, 0, 0, mk("lw_w1",     1, 0, 1, 0, 0, 0, 0, 2, 'h104));
        step(I_ADDI, 32'h108, 1, 0, 0, 0, 0, mk("lw_w2",     1, 0, 1, 0, 0, 0, 0, 2, 'h104));
        step(I_ADDI, 32'h108, 1, 0, 0, 0, 0, mk("lw_done",   1, 0, 0, 0, 1, 0, 0, 2, 'h104));
        step(I_ADDI, 32'h108, 1, 0, 0, 0, 0, mk("addi2",     1, 0, 0, 0, 1, 0, 1, 2, 'h108));

        // Branch mispredict, correct prediction, jumps
        step(I_BEQ,  32'h10C, 1, 1, 0, 0, 0, mk("beq_mis",   1, 1, 0, 1, 0, 0, DC, 2, 'h10C));
        step(I_ADDI, 32'h110, 1, 0, 0, 0, 0, mk("beq_bub",   0, 0, 0, 0, 0, 0, DC, DC, 'h110));
        step(I_BEQ,  32'h114, 1, 1, 1, 0, 0, mk("beq_ok",    1, 0, 0, 0, 0, 0, DC, DC, 'h114));
        step(I_JAL0, 32'h118, 1, 0, 0, 0, 0, mk("jal_x0",    1, 2, 0, 1, 0, 0, 2, DC, 'h118));
        step(I_ADDI, 32'h11C, 1, 0, 0, 0, 0, mk("jal0_bub",  0, 0, 0, 0, 0, 0, DC, DC, 'h11C));
        step(I_JAL1, 32'h120, 1, 0, 0, 0, 0, mk("jal_x1",    1, 2, 0, 1, 1, 0, 2, DC, 'h120));
        step(I_ADDI, 32'h124, 1, 0, 0, 0, 0, mk("jal1_bub",  0, 0, 0, 0, 0, 0, DC, DC, 'h124));

        // CSR, unknown opcode and ecall
        step(I_CSRRW, 32'h128, 1, 0, 0, 0, 0, mk("csrrw",    1, 0, 0, 0, 0, 1, 1, DC, 'h128));
        step(I_CUST,  32'h12C, 1, 0, 0, 0, 0, mk("unknown",  1, 0, 0, 0, 0, 0, 1, 2, 'h12C));
        step(I_ECALL, 32'h130, 1, 0, 0, 0, 0, mk("ecall",    1, 0, 0, 0, 0, 0, 1, DC, 'h130));

        // JALR redirect held by stall_in for three cycles
        step(I_JALR, 32'h134, 1, 0, 0, 0, 0, mk("jalr",      1, 1, 0, 1, 1, 0, 2, DC, 'h134));
        for (int i = 0; i < 3; i++)
            step(I_ADDI, 32'h138, 1, 0, 0, 1, 0, mk("jalr_hold", 1, 1, 0, 1, 1, 0, 2, DC, 'h134));
        step(I_ADDI, 32'h138, 1, 0, 0, 0, 0, mk("jalr_bub",  0, 0, 0, 0, 0, 0, DC, DC, 'h138));
        step(I_ADDI, 32'h13C, 1, 0, 0, 0, 0, mk("post_bub",  1, 0, 0, 0, 1, 0, 1, DC, 'h13C));

        // stall_in freezes the load-wait counter
        step(I_LW,   32'h140, 1, 0, 0, 0, 0, mk("lw2_w1",    1, 0, 1, 0, 0, 0, 0, 2, 'h140));
        step(I_LBU,  32'h144, 1, 0, 0, 1, 0, mk("lw2_frz",   1, 0, 1, 0, 0, 0, 0, 2, 'h140));
        step(I_LBU,  32'h144, 1, 0, 0, 0, 0, mk("lw2_w2",    1, 0, 1, 0, 0, 0, 0, 2, 'h140));
        step(I_LBU,  32'h144, 1, 0, 0, 0, 0, mk("lw2_done",  1, 0, 0, 0, 1, 0, 0, 2, 'h140));

        // Reset during the second load-wait cycle
        step(I_LBU,  32'h144, 1, 0, 0, 0, 0, mk("lbu_w1",    1, 0, 1, 0, 0, 0, 0, 4, 'h144));
        step(I_ADDI, 32'h148, 1, 0, 0, 0, 0, mk("lbu_w2",    1, 0, 1, 0, 0, 0, 0, 4, 'h144));
        step(I_ADDI, 32'h148, 1, 0, 0, 0, 1, mk("rst_lw",    0, 3, 0, 0, 0, 0, DC, DC, 0));
        check("rst_lw.inst_s3", inst_s3, I_NOP);
        step(I_ADDI, 32'h148, 1, 0, 0, 0, 0, mk("boot1b",    0, 3, 0, 0, 0, 0, DC, DC, 0));
        step(I_ADDI, 32'h148, 1, 0, 0, 0, 0, mk("boot_exit_b", 0, 0, 0, 0, 0, 0, DC, DC, 0));
        step(I_ADDI, 32'h200, 0, 0, 0, 0, 0, mk("invalid_in", 0, 0, 0, 0, 0, 0, DC, DC, 'h200));
        step(I_ADDI, 32'h204, 1, 0, 0, 0, 0, mk("addi3",     1, 0, 0, 0, 1, 0, 1, 2, 'h204));

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_leftover: got=%0d entries exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
